// File: rtl/dphy_pkg.sv
// rtl/dphy_pkg.sv - shared D-PHY encodings: HS FSM states, LP line levels, lane sequencer states
package dphy_pkg;

  typedef enum logic [2:0] {
    HS_STOP  = 3'd0,
    HS_ZERO  = 3'd1,
    HS_SYNC  = 3'd2,
    HS_DATA  = 3'd3,
    HS_TRAIL = 3'd4
  } hs_state_t;

  // LP line states as {Dp, Dn}
  localparam logic [1:0] LP11 = 2'b11;
  localparam logic [1:0] LP01 = 2'b01;
  localparam logic [1:0] LP00 = 2'b00;
  localparam logic [1:0] LP10 = 2'b10;

  typedef enum logic [2:0] {
    SEQ_INIT   = 3'd0,
    SEQ_STOP   = 3'd1,
    SEQ_RQST   = 3'd2,
    SEQ_PREP   = 3'd3,
    SEQ_ACTIVE = 3'd4,
    SEQ_EXIT   = 3'd5
  } seq_state_t;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/tx_hs_lane_seq.sv
// rtl/tx_hs_lane_seq.sv - D-PHY TX data lane LP->HS->LP sequencer
// Drives LP line levels and driver enables around each HS burst.
module tx_hs_lane_seq
  import dphy_pkg::*;
#(
  parameter int T_INIT       = 16,
  parameter int T_LPX        = 2,
  parameter int T_HS_PREPARE = 3,
  parameter int T_HS_EXIT    = 4
) (
  input  logic       TX_DDR_clk,
  input  logic       TX_rst,
  input  logic       TX_REQUEST_HS,
  input  logic [2:0] TX_HS_STATE,
  output logic       HS_FSM_EN,
  output logic       TX_HS_END_DATA,
  output logic       LP_DP,
  output logic       LP_DN,
  output logic       LP_DRV_EN,
  output logic       HS_DRV_EN,
  output logic       TX_STOPSTATE,
  output logic       TX_BUSY
);

  localparam int CW = $clog2(max4(T_INIT, T_LPX, T_HS_PREPARE, T_HS_EXIT) + 1);

  seq_state_t    r_state;
  seq_state_t    w_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_load;
  logic          r_trail_seen;
  logic          w_cnt_done;
  logic [1:0]    w_lp;

  assign w_cnt_done = (r_cnt == '0);

  always_ff @(posedge TX_DDR_clk or posedge TX_rst) begin
    if (TX_rst) begin
      r_state      <= SEQ_INIT;
      r_cnt        <= CW'(T_INIT - 1);
      r_trail_seen <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state)
        r_cnt <= w_load;
      else if (!w_cnt_done)
        r_cnt <= r_cnt - 1'b1;
      // trail_seen only lives inside ACTIVE; any other state clears it
      r_trail_seen <= (r_state == SEQ_ACTIVE) &&
                      (r_trail_seen || (TX_HS_STATE == HS_TRAIL));
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      SEQ_INIT:   if (w_cnt_done) w_next = SEQ_STOP;
      SEQ_STOP:   if (TX_REQUEST_HS) w_next = SEQ_RQST;
      SEQ_RQST: begin
        if (!TX_REQUEST_HS)  w_next = SEQ_EXIT;
        else if (w_cnt_done) w_next = SEQ_PREP;
      end
      SEQ_PREP: begin
        if (!TX_REQUEST_HS)  w_next = SEQ_EXIT;
        else if (w_cnt_done) w_next = SEQ_ACTIVE;
      end
      SEQ_ACTIVE: if (r_trail_seen && TX_HS_STATE == HS_STOP) w_next = SEQ_EXIT;
      SEQ_EXIT:   if (w_cnt_done) w_next = SEQ_STOP;
      default:    w_next = SEQ_INIT;
    endcase
  end

  always_comb begin
    w_load = '0;
    case (w_next)
      SEQ_INIT: w_load = CW'(T_INIT - 1);
      SEQ_RQST: w_load = CW'(T_LPX - 1);
      SEQ_PREP: w_load = CW'(T_HS_PREPARE - 1);
      SEQ_EXIT: w_load = CW'(T_HS_EXIT - 1);
      default:  w_load = '0;
    endcase
  end

  always_comb begin
    w_lp         = LP11;
    LP_DRV_EN    = 1'b1;
    HS_DRV_EN    = 1'b0;
    HS_FSM_EN    = 1'b0;
    TX_STOPSTATE = 1'b0;
    TX_BUSY      = 1'b0;
    case (r_state)
      SEQ_STOP: TX_STOPSTATE = 1'b1;
      SEQ_RQST: begin
        w_lp    = LP01;
        TX_BUSY = 1'b1;
      end
      SEQ_PREP: begin
        w_lp      = LP00;
        HS_DRV_EN = 1'b1;
        TX_BUSY   = 1'b1;
      end
      SEQ_ACTIVE: begin
        w_lp      = LP00;
        LP_DRV_EN = 1'b0;
        HS_DRV_EN = 1'b1;
        HS_FSM_EN = 1'b1;
        TX_BUSY   = 1'b1;
      end
      SEQ_EXIT: TX_BUSY = 1'b1;
      default: ;
    endcase
  end

  assign LP_DP = w_lp[1];
  assign LP_DN = w_lp[0];

  // End-of-data follows the live request so the HS FSM sees it in the same cycle
  assign TX_HS_END_DATA = (r_state == SEQ_ACTIVE) && !TX_REQUEST_HS &&
                          (TX_HS_STATE == HS_DATA);

endmodule

// File: tb/tb_tx_hs_lane_seq.sv
// tb/tb_tx_hs_lane_seq.sv - scoreboard bench for the TX data lane sequencer
module tb_tx_hs_lane_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req = 1'b0;
  logic [2:0] hs  = 3'd0;
  logic       hs_fsm_en, end_data, lp_dp, lp_dn, lp_drv_en, hs_drv_en, stopstate, busy;

  tx_hs_lane_seq dut (
    .TX_DDR_clk    (clk),
    .TX_rst        (rst),
    .TX_REQUEST_HS (req),
    .TX_HS_STATE   (hs),
    .HS_FSM_EN     (hs_fsm_en),
    .TX_HS_END_DATA(end_data),
    .LP_DP         (lp_dp),
    .LP_DN         (lp_dn),
    .LP_DRV_EN     (lp_drv_en),
    .HS_DRV_EN     (hs_drv_en),
    .TX_STOPSTATE  (stopstate),
    .TX_BUSY       (busy)
  );

  always #5 clk = ~clk;

  // {HS_FSM_EN, END_DATA, Dp, Dn, LP_DRV_EN, HS_DRV_EN, STOPSTATE, BUSY}
  localparam logic [7:0] O_INIT    = 8'b0011_1000;
  localparam logic [7:0] O_STOP    = 8'b0011_1010;
  localparam logic [7:0] O_RQST    = 8'b0001_1001;
  localparam logic [7:0] O_PREP    = 8'b0000_1101;
  localparam logic [7:0] O_ACT     = 8'b1000_0101;
  localparam logic [7:0] O_ACT_END = 8'b1100_0101;
  localparam logic [7:0] O_EXIT    = 8'b0011_1001;

  typedef struct {
    string      tag;
    logic [7:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  wire [7:0] w_obs = {hs_fsm_en, end_data, lp_dp, lp_dn, lp_drv_en, hs_drv_en, stopstate, busy};

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [7:0] exp);
    sb_t s;
    s.tag = tag;
    s.exp = exp;
    sb_q.push_back(s);
  endtask

  task automatic sb_pop_compare();
    sb_t s;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_empty: got no entry expected one");
    end else begin
      s = sb_q.pop_front();
      check_eq(s.tag, w_obs, s.exp);
    end
  endtask

  // Drive one cycle's inputs just after the edge, compare outputs on the falling edge
  task automatic cyc(input logic r, input logic [2:0] h, input logic [7:0] e, input string tag);
    req = r;
    hs  = h;
    sb_push(tag, e);
    @(negedge clk);
    sb_pop_compare();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of stimulus");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    @(posedge clk);
    #1;
    cyc(1'b0, 3'd0, O_INIT, "reset_hold");
    rst = 1'b0;

    for (int i = 0; i < 16; i++)
      cyc((i >= 8 && i < 12), 3'd0, O_INIT, "init");
    cyc(1'b0, 3'd0, O_STOP, "stop_first");
    cyc(1'b0, 3'd0, O_STOP, "stop_idle");

    // full burst with a modelled HS FSM: ZERO x4, SYNC x4, DATA, TRAIL x8
    cyc(1'b1, 3'd0, O_STOP, "stop_req");
    for (int i = 0; i < 2; i++) cyc(1'b1, 3'd0, O_RQST, "rqst");
    for (int i = 0; i < 3; i++) cyc(1'b1, 3'd0, O_PREP, "prep");
    cyc(1'b1, 3'd0, O_ACT, "act_en");
    for (int i = 0; i < 4; i++) cyc(1'b1, 3'd1, O_ACT, "zero");
    for (int i = 0; i < 4; i++) cyc(1'b1, 3'd2, O_ACT, "sync");
    for (int i = 0; i < 3; i++) cyc(1'b1, 3'd3, O_ACT, "data");
    cyc(1'b0, 3'd3, O_ACT_END, "end_data");
    for (int i = 0; i < 8; i++) cyc(1'b0, 3'd4, O_ACT, "trail");
    cyc(1'b0, 3'd0, O_ACT, "hs_stop");
    for (int i = 0; i < 4; i++) cyc(1'b0, 3'd0, O_EXIT, "exit");
    cyc(1'b0, 3'd0, O_STOP, "stop_after_exit");

    // abort during the second PREP cycle
    cyc(1'b1, 3'd0, O_STOP, "stop_req2");
    for (int i = 0; i < 2; i++) cyc(1'b1, 3'd0, O_RQST, "rqst2");
    cyc(1'b1, 3'd0, O_PREP, "prep1");
    cyc(1'b0, 3'd0, O_PREP, "prep2_drop");
    for (int i = 0; i < 4; i++) cyc(1'b0, 3'd0, O_EXIT, "abort_exit");
    cyc(1'b0, 3'd0, O_STOP, "abort_stop");

    // early drop, illegal HS states, then request held through EXIT
    cyc(1'b1, 3'd0, O_STOP, "stop_req3");
    for (int i = 0; i < 2; i++) cyc(1'b1, 3'd0, O_RQST, "rqst3");
    for (int i = 0; i < 3; i++) cyc(1'b1, 3'd0, O_PREP, "prep3");
    cyc(1'b1, 3'd0, O_ACT, "act_en3");
    cyc(1'b1, 3'd1, O_ACT, "zero3");
    cyc(1'b0, 3'd7, O_ACT, "hs_illegal7");
    cyc(1'b0, 3'd6, O_ACT, "hs_illegal6");
    cyc(1'b0, 3'd0, O_ACT, "stop_no_trail");
    cyc(1'b0, 3'd2, O_ACT, "early_drop");
    cyc(1'b0, 3'd3, O_ACT_END, "end_data3");
    cyc(1'b1, 3'd4, O_ACT, "trail3");
    cyc(1'b1, 3'd0, O_ACT, "hs_stop3");
    for (int i = 0; i < 4; i++) cyc(1'b1, 3'd0, O_EXIT, "exit_req_high");
    cyc(1'b1, 3'd0, O_STOP, "b2b_stop");
    cyc(1'b1, 3'd0, O_RQST, "b2b_rqst");

    // asynchronous reset while ACTIVE
    cyc(1'b1, 3'd0, O_RQST, "b2b_rqst2");
    for (int i = 0; i < 3; i++) cyc(1'b1, 3'd0, O_PREP, "b2b_prep");
    cyc(1'b1, 3'd1, O_ACT, "act_pre_rst");
    rst = 1'b1;
    #1;
    sb_push("rst_async", O_INIT);
    sb_pop_compare();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 16; i++) cyc(1'b1, 3'd1, O_INIT, "reinit");
    cyc(1'b1, 3'd0, O_STOP, "reinit_stop");
    cyc(1'b0, 3'd0, O_RQST, "reinit_rqst");
    cyc(1'b0, 3'd0, O_EXIT, "reinit_abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
